// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX arbiter and its helpers.
//   arb_state_t  - arbiter FSM states
//   MAC_BYTE_W   - width of one byte lane towards mac_transmit
//   MAX_SRC      - largest supported number of frame sources
//   SRC_IDX_W    - width of a source index (covers MAX_SRC)
//   next_idx()   - round-robin successor of a source index
package eth_pkg;

  localparam int unsigned MAC_BYTE_W = 8;
  localparam int unsigned MAX_SRC    = 8;
  localparam int unsigned SRC_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    SENT,
    DRAIN
  } arb_state_t;

  // Index following idx, wrapping at n (idx is assumed < n).
  function automatic logic [SRC_IDX_W-1:0] next_idx(input logic [SRC_IDX_W-1:0] idx,
                                                   input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end
    return idx + SRC_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Returns the first asserted request at or above ptr, wrapping to index 0.
//   req    in   N          request vector
//   ptr    in   SRC_IDX_W  highest-priority index (must be < N)
//   onehot out  N          one-hot of the chosen request (zero if none)
//   idx    out  SRC_IDX_W  index of the chosen request (zero if none)
//   found  out  1          any request present
module rr_picker
  import eth_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [SRC_IDX_W-1:0] idx,
  output logic                 found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    // First pass: indices from ptr upward.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        onehot[i] = 1'b1;
        idx       = SRC_IDX_W'(i);
        found     = 1'b1;
      end
    end
    // Second pass: wrapped part, indices below ptr.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        onehot[i] = 1'b1;
        idx       = SRC_IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one mac_transmit between N_SRC byte-stream frame sources.
// A grant is held from request until the MAC has finished the frame (busy falls), or until
// the source fails to send / the MAC fails to start, in which case the grant is revoked and
// a saturating counter is bumped.
//   clk_100mhz        in   1          system clock
//   rst               in   1          synchronous active-high reset
//   req_in            in   N_SRC      per-source frame request (level)
//   grant_out         out  N_SRC      one-hot grant, zero when idle
//   src_data_in       in   8*N_SRC    packed source bytes, source i at [8i+7:8i]
//   src_valid_in      in   N_SRC      per-source byte valid
//   src_send_in       in   N_SRC      per-source send strobe
//   mac_data_out      out  8          granted source byte
//   mac_valid_out     out  1          granted source valid
//   mac_send_out      out  1          granted source send strobe
//   mac_busy_in       in   1          MAC busy
//   active_src_out    out  3          granted source index, 0 when idle
//   timeout_count_out out  16         saturating count of revoked grants
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned N_SRC         = 2,
  parameter int unsigned GRANT_TIMEOUT = 4096,
  parameter int unsigned BUSY_TIMEOUT  = 64
) (
  input  logic                        clk_100mhz,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            req_in,
  output logic [N_SRC-1:0]            grant_out,
  input  logic [MAC_BYTE_W*N_SRC-1:0] src_data_in,
  input  logic [N_SRC-1:0]            src_valid_in,
  input  logic [N_SRC-1:0]            src_send_in,
  output logic [MAC_BYTE_W-1:0]       mac_data_out,
  output logic                        mac_valid_out,
  output logic                        mac_send_out,
  input  logic                        mac_busy_in,
  output logic [2:0]                  active_src_out,
  output logic [15:0]                 timeout_count_out
);

  localparam int unsigned TIMER_MAX = (GRANT_TIMEOUT > BUSY_TIMEOUT) ? GRANT_TIMEOUT
                                                                    : BUSY_TIMEOUT;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] GRANT_LAST = TIMER_W'(GRANT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BUSY_LAST  = TIMER_W'(BUSY_TIMEOUT - 1);

  arb_state_t           state, state_next;
  logic [N_SRC-1:0]     grant, grant_next;
  logic [SRC_IDX_W-1:0] active_idx, active_idx_next;
  logic [SRC_IDX_W-1:0] rr_ptr, rr_ptr_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [15:0]          timeout_count, timeout_count_next;

  logic [N_SRC-1:0]     pick_onehot;
  logic [SRC_IDX_W-1:0] pick_idx;
  logic                 pick_found;
  logic                 granted_req;
  logic                 granted_send;
  logic                 release_grant;
  logic                 bump_timeout;

  rr_picker #(
    .N (N_SRC)
  ) u_picker (
    .req    (req_in),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Datapath: only the granted lane reaches the MAC; no grant gives all zeros.
  always_comb begin
    mac_data_out = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        mac_data_out = mac_data_out | src_data_in[MAC_BYTE_W*i +: MAC_BYTE_W];
      end
    end
  end

  assign mac_valid_out = |(grant & src_valid_in);
  assign mac_send_out  = |(grant & src_send_in);
  assign granted_req   = |(grant & req_in);
  assign granted_send  = |(grant & src_send_in);

  always_comb begin
    state_next         = state;
    grant_next         = grant;
    active_idx_next    = active_idx;
    rr_ptr_next        = rr_ptr;
    timer_next         = timer;
    timeout_count_next = timeout_count;
    release_grant      = 1'b0;
    bump_timeout       = 1'b0;

    case (state)
      IDLE: begin
        if (!mac_busy_in && pick_found) begin
          grant_next      = pick_onehot;
          active_idx_next = pick_idx;
          timer_next      = '0;
          state_next      = GRANTED;
        end
      end
      GRANTED: begin
        // Send takes priority over a same-cycle request drop or timeout.
        if (granted_send) begin
          timer_next = '0;
          state_next = SENT;
        end else if (!granted_req) begin
          release_grant = 1'b1;
        end else if (timer == GRANT_LAST) begin
          release_grant = 1'b1;
          bump_timeout  = 1'b1;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      SENT: begin
        if (mac_busy_in) begin
          state_next = DRAIN;
        end else if (timer == BUSY_LAST) begin
          release_grant = 1'b1;
          bump_timeout  = 1'b1;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      DRAIN: begin
        if (!mac_busy_in) begin
          release_grant = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    // Every release drops through IDLE, so grant_out is zero for at least one cycle.
    if (release_grant) begin
      grant_next      = '0;
      active_idx_next = '0;
      rr_ptr_next     = next_idx(active_idx, N_SRC);
      timer_next      = '0;
      state_next      = IDLE;
    end

    if (bump_timeout && (timeout_count != 16'hFFFF)) begin
      timeout_count_next = timeout_count + 16'd1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      active_idx    <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      active_idx    <= active_idx_next;
      rr_ptr        <= rr_ptr_next;
      timer         <= timer_next;
      timeout_count <= timeout_count_next;
    end
  end

  assign grant_out         = grant;
  assign active_src_out    = 3'(active_idx);
  assign timeout_count_out = timeout_count;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter (N_SRC=2, GRANT_TIMEOUT=16, BUSY_TIMEOUT=8).
// Stimulus pushes expected grants and MAC bytes; a negedge monitor pops and compares.
module tb_eth_tx_arbiter;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic [1:0]  req_in;
  logic [1:0]  grant_out;
  logic [15:0] src_data_in;
  logic [1:0]  src_valid_in;
  logic [1:0]  src_send_in;
  logic [7:0]  mac_data_out;
  logic        mac_valid_out;
  logic        mac_send_out;
  logic        mac_busy_in;
  logic [2:0]  active_src_out;
  logic [15:0] timeout_count_out;

  always #5 clk_100mhz = ~clk_100mhz;

  eth_tx_arbiter #(
    .N_SRC         (2),
    .GRANT_TIMEOUT (16),
    .BUSY_TIMEOUT  (8)
  ) dut (
    .clk_100mhz        (clk_100mhz),
    .rst               (rst),
    .req_in            (req_in),
    .grant_out         (grant_out),
    .src_data_in       (src_data_in),
    .src_valid_in      (src_valid_in),
    .src_send_in       (src_send_in),
    .mac_data_out      (mac_data_out),
    .mac_valid_out     (mac_valid_out),
    .mac_send_out      (mac_send_out),
    .mac_busy_in       (mac_busy_in),
    .active_src_out    (active_src_out),
    .timeout_count_out (timeout_count_out)
  );

  int checks = 0;
  int errors = 0;
  int sends_seen = 0;
  int exp_sends = 0;
  int bytes_seen = 0;
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_grants[$];
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] mon_e;
  logic [7:0] mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares MAC bytes and new grants against the scoreboard queues.
  always @(negedge clk_100mhz) begin
    if (rst) begin
      prev_grant = grant_out;
    end else begin
      if (mac_valid_out) begin
        bytes_seen++;
        if (exp_bytes.size() == 0) begin
          chk("byte_unexpected", 32'(mac_data_out), 32'h100);
        end else begin
          mon_b = exp_bytes.pop_front();
          chk("byte", 32'(mac_data_out), 32'(mon_b));
        end
      end
      if (mac_send_out) sends_seen++;
      if (grant_out != prev_grant) begin
        if (prev_grant != 2'b00) begin
          chk("grant_gap", 32'(grant_out), 32'd0);
        end else if (exp_grants.size() == 0) begin
          chk("grant_unexpected", 32'(grant_out), 32'd0);
        end else begin
          mon_e = exp_grants.pop_front();
          chk("grant", 32'(grant_out), 32'(mon_e));
          chk("active_src", 32'(active_src_out), (mon_e == 2'b10) ? 32'd1 : 32'd0);
        end
      end
      prev_grant = grant_out;
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset;
    tick;
    rst = 1'b1; req_in = '0; src_valid_in = '0; src_send_in = '0;
    src_data_in = '0; mac_busy_in = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Returns at a negedge once grant_out == g, or after a bounded wait.
  task automatic wait_grant(input logic [1:0] g);
    int n = 0;
    while (grant_out != g && n < 40) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("grant_wait", 32'(grant_out), 32'(g));
  endtask

  // One frame from src: send pulse, busy for busy_cycles with nbytes valid bytes.
  // With noise, the other source strobes valid/send/data that must not reach the MAC.
  task automatic run_frame(input int src, input int nbytes, input int busy_cycles,
                           input bit noise);
    int oth = 1 - src;
    int bad = 0;
    logic [1:0] g;
    logic [7:0] b;
    g = (src == 0) ? 2'b01 : 2'b10;
    wait_grant(g);
    tick;
    src_send_in[src] = 1'b1;
    exp_sends++;
    if (noise) begin
      src_send_in[oth] = 1'b1;
      src_valid_in[oth] = 1'b1;
      src_data_in[8*oth +: 8] = 8'hEE;
    end
    tick;
    src_send_in = '0;
    src_valid_in = '0;
    mac_busy_in = 1'b1;
    for (int i = 0; i < busy_cycles; i++) begin
      if (i < nbytes) begin
        b = 8'(src * 128 + i);
        src_valid_in[src] = 1'b1;
        src_data_in[8*src +: 8] = b;
        exp_bytes.push_back(b);
      end else begin
        src_valid_in[src] = 1'b0;
      end
      if (noise) begin
        src_valid_in[oth] = (i % 3 == 0);
        src_send_in[oth] = (i == 5);
      end
      tick;
      if (grant_out != g) bad++;
    end
    src_valid_in = '0;
    src_send_in = '0;
    mac_busy_in = 1'b0;
    chk("grant_held", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_in = '0; src_valid_in = '0; src_send_in = '0;
    src_data_in = '0; mac_busy_in = 1'b0;
    repeat (3) tick;

    // Reset state, with junk on the source lanes.
    src_valid_in = 2'b11; src_send_in = 2'b11; src_data_in = 16'hA55A;
    @(negedge clk_100mhz);
    chk("rst_grant", 32'(grant_out), 32'd0);
    chk("rst_mac_data", 32'(mac_data_out), 32'd0);
    chk("rst_mac_valid", 32'(mac_valid_out), 32'd0);
    chk("rst_mac_send", 32'(mac_send_out), 32'd0);
    chk("rst_active", 32'(active_src_out), 32'd0);
    chk("rst_tcount", 32'(timeout_count_out), 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk_100mhz);
    chk("nogrant_mac_data", 32'(mac_data_out), 32'd0);
    chk("nogrant_mac_valid", 32'(mac_valid_out), 32'd0);
    chk("nogrant_mac_send", 32'(mac_send_out), 32'd0);
    tick;
    src_valid_in = '0; src_send_in = '0; src_data_in = '0;

    // Single source, 64-byte frame, MAC busy for 600 cycles.
    exp_grants.push_back(2'b01);
    tick;
    req_in = 2'b01;
    @(negedge clk_100mhz);
    chk("t1_pre_grant", 32'(grant_out), 32'd0);
    @(negedge clk_100mhz);
    chk("t1_grant_latency", 32'(grant_out), 32'd1);
    bytes_seen = 0;
    run_frame(0, 64, 600, 1'b0);
    req_in = 2'b00;
    repeat (3) tick;
    chk("t1_bytes", 32'(bytes_seen), 32'd64);
    chk("t1_released", 32'(grant_out), 32'd0);

    // Both sources requesting: grants alternate, other lane's strobes are dropped.
    do_reset;
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b10);
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b10);
    req_in = 2'b11;
    for (int f = 0; f < 4; f++) run_frame(f % 2, 8, 12, 1'b1);
    req_in = 2'b00;
    repeat (3) tick;

    // Grant timeout: source 0 never sends, source 1 next; then source 1 drops its request.
    do_reset;
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b10);
    req_in = 2'b11;
    wait_grant(2'b01);
    n = 0;
    while (grant_out == 2'b01 && n < 100) begin
      n++;
      @(negedge clk_100mhz);
    end
    chk("gto_len", 32'(n), 32'd16);
    chk("gto_count", 32'(timeout_count_out), 32'd1);
    wait_grant(2'b10);
    tick;
    req_in = 2'b00;
    tick;
    tick;
    @(negedge clk_100mhz);
    chk("drop_grant", 32'(grant_out), 32'd0);
    chk("drop_count", 32'(timeout_count_out), 32'd1);

    // Busy timeout: send pulse, MAC never goes busy.
    do_reset;
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b01);
    req_in = 2'b01;
    wait_grant(2'b01);
    tick;
    src_send_in[0] = 1'b1;
    exp_sends++;
    tick;
    src_send_in = '0;
    n = 0;
    do begin
      @(negedge clk_100mhz);
      if (grant_out == 2'b01) n++;
    end while (grant_out == 2'b01 && n < 50);
    chk("bto_len", 32'(n), 32'd8);
    chk("bto_count", 32'(timeout_count_out), 32'd1);

    // Reset while draining with the MAC busy.
    wait_grant(2'b01);
    tick;
    src_send_in[0] = 1'b1;
    exp_sends++;
    tick;
    src_send_in = '0;
    mac_busy_in = 1'b1;
    tick;
    src_valid_in[0] = 1'b1;
    src_data_in[7:0] = 8'h5A;
    exp_bytes.push_back(8'h5A);
    tick;
    chk("t6_pre_count", 32'(timeout_count_out), 32'd1);
    rst = 1'b1;
    tick;
    @(negedge clk_100mhz);
    chk("t6_grant", 32'(grant_out), 32'd0);
    chk("t6_mac_data", 32'(mac_data_out), 32'd0);
    chk("t6_mac_valid", 32'(mac_valid_out), 32'd0);
    chk("t6_mac_send", 32'(mac_send_out), 32'd0);
    chk("t6_active", 32'(active_src_out), 32'd0);
    chk("t6_tcount", 32'(timeout_count_out), 32'd0);
    tick;
    rst = 1'b0; req_in = '0; src_valid_in = '0; src_data_in = '0; mac_busy_in = 1'b0;

    repeat (5) tick;
    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("grants_left", 32'(exp_grants.size()), 32'd0);
    chk("send_count", 32'(sends_seen), 32'(exp_sends));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
